// File: rtl/butterfly_pipe.sv
// Four-stage modular butterfly for the NTT/INTT datapath: CT-NTT, GS-INTT,
// pointwise multiply and pass-through, with valid/ready flow control.
module butterfly_pipe #(
  parameter int WIDTH      = 32,
  parameter int Q          = 8380417,
  parameter int TAG_W      = 8,
  parameter int HALVE_INTT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_w,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic [TAG_W-1:0] out_tag
);

  localparam int QB = $clog2(Q + 1);
  localparam int PW = 2 * QB;
  localparam int MW = QB + 1;
  localparam logic [63:0]    BARRETT_M = (64'd1 << PW) / 64'(Q);
  localparam logic [MW-1:0]  BM = MW'(BARRETT_M);
  localparam logic [QB-1:0]  QV = QB'(Q);

  localparam logic [1:0] MODE_CT = 2'b00;
  localparam logic [1:0] MODE_GS = 2'b01;
  localparam logic [1:0] MODE_PW = 2'b10;

  function automatic logic [QB-1:0] norm(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] s;
    if (x[WIDTH-1]) s = x + WIDTH'(Q);
    else            s = x;
    return QB'(s);
  endfunction

  function automatic logic [QB-1:0] mod_add(input logic [QB-1:0] a, input logic [QB-1:0] b);
    logic [QB:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, QV}) s = s - {1'b0, QV};
    else                 s = s;
    return QB'(s);
  endfunction

  // Wraps modulo 2^(QB+1); adding Q back lands in [1, Q) when a < b.
  function automatic logic [QB-1:0] mod_sub(input logic [QB-1:0] a, input logic [QB-1:0] b);
    logic [QB:0] s;
    s = {1'b0, a} - {1'b0, b};
    if (a < b) s = s + {1'b0, QV};
    else       s = s;
    return QB'(s);
  endfunction

  function automatic logic [QB-1:0] halve(input logic [QB-1:0] r);
    logic [QB:0] t;
    if (r[0]) t = {1'b0, r} + {1'b0, QV};
    else      t = {1'b0, r};
    return QB'(t >> 1);
  endfunction

  // The quotient estimate undershoots by at most one, so r < 2Q before correction.
  function automatic logic [QB-1:0] barrett(input logic [PW-1:0] p);
    logic [PW+MW-1:0] prod;
    logic [MW-1:0]    qe;
    logic [PW-1:0]    qq;
    logic [QB+1:0]    r;
    prod = (PW+MW)'(p) * (PW+MW)'(BM);
    qe   = MW'(prod >> PW);
    qq   = PW'(qe) * PW'(Q);
    r    = (QB+2)'(p - qq);
    if (r >= (QB+2)'(Q)) r = r - (QB+2)'(Q);
    else                 r = r;
    if (r >= (QB+2)'(Q)) r = r - (QB+2)'(Q);
    else                 r = r;
    return QB'(r);
  endfunction

  logic             en_s;
  logic             v0_r, v1_r, v2_r, v3_r;
  logic [1:0]       mode0_r, mode1_r, mode2_r;
  logic [TAG_W-1:0] tag0_r, tag1_r, tag2_r, tag3_r;
  logic [QB-1:0]    a0_r, b0_r, w0_r;
  logic [PW-1:0]    p1_r;
  logic [QB-1:0]    x1_r, y1_r, x2_r, y2_r, r2_r;
  logic [QB-1:0]    c3_r, d3_r;
  logic [QB-1:0]    sum_s, diff_s, mul_x_s, mul_y_s, x1_s;
  logic [PW-1:0]    prod_s;
  logic [QB-1:0]    c_s, d_s;

  assign en_s      = ~v3_r | out_ready;
  assign in_ready  = en_s;
  assign out_valid = v3_r;
  assign out_c     = {{(WIDTH-QB){1'b0}}, c3_r};
  assign out_d     = {{(WIDTH-QB){1'b0}}, d3_r};
  assign out_tag   = tag3_r;

  // S1: GS pre-add/sub and operand selection for the shared multiplier
  always_comb begin
    sum_s   = mod_add(a0_r, b0_r);
    diff_s  = mod_sub(a0_r, b0_r);
    mul_x_s = a0_r;
    mul_y_s = b0_r;
    x1_s    = a0_r;
    case (mode0_r)
      MODE_CT: begin mul_x_s = w0_r; mul_y_s = b0_r; x1_s = a0_r; end
      MODE_GS: begin mul_x_s = diff_s; mul_y_s = w0_r; x1_s = sum_s; end
      default: begin mul_x_s = a0_r; mul_y_s = b0_r; x1_s = a0_r; end
    endcase
    prod_s = PW'(mul_x_s) * PW'(mul_y_s);
  end

  // S3: CT post-add/sub, optional INTT halving and result selection
  always_comb begin
    c_s = x2_r;
    d_s = y2_r;
    case (mode2_r)
      MODE_CT: begin c_s = mod_add(x2_r, r2_r); d_s = mod_sub(x2_r, r2_r); end
      MODE_GS: begin
        if (HALVE_INTT != 0) begin c_s = halve(x2_r); d_s = halve(r2_r); end
        else                 begin c_s = x2_r;        d_s = r2_r;        end
      end
      MODE_PW: begin c_s = r2_r; d_s = '0; end
      default: begin c_s = x2_r; d_s = y2_r; end
    endcase
  end

  // Pipeline registers: every stage advances together on en_s
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_r <= 1'b0; v1_r <= 1'b0; v2_r <= 1'b0; v3_r <= 1'b0;
      mode0_r <= 2'b00; mode1_r <= 2'b00; mode2_r <= 2'b00;
      tag0_r <= '0; tag1_r <= '0; tag2_r <= '0; tag3_r <= '0;
      a0_r <= '0; b0_r <= '0; w0_r <= '0;
      p1_r <= '0; x1_r <= '0; y1_r <= '0;
      r2_r <= '0; x2_r <= '0; y2_r <= '0;
      c3_r <= '0; d3_r <= '0;
    end else if (en_s) begin
      v0_r    <= in_valid;
      mode0_r <= in_mode;
      tag0_r  <= in_tag;
      a0_r    <= norm(in_a);
      b0_r    <= norm(in_b);
      w0_r    <= norm(in_w);

      v1_r    <= v0_r;
      mode1_r <= mode0_r;
      tag1_r  <= tag0_r;
      p1_r    <= prod_s;
      x1_r    <= x1_s;
      y1_r    <= b0_r;

      v2_r    <= v1_r;
      mode2_r <= mode1_r;
      tag2_r  <= tag1_r;
      r2_r    <= barrett(p1_r);
      x2_r    <= x1_r;
      y2_r    <= y1_r;

      v3_r    <= v2_r;
      tag3_r  <= tag2_r;
      c3_r    <= c_s;
      d3_r    <= d_s;
    end
  end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Scoreboard bench for butterfly_pipe: plain and halving instances share stimulus.
module tb_butterfly_pipe;
  localparam int WIDTH = 32;
  localparam int Q     = 8380417;
  localparam int TAG_W = 8;
  localparam longint QL = 64'(Q);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b1;
  logic [1:0]       in_mode = 2'b00;
  logic [WIDTH-1:0] in_a = '0, in_b = '0, in_w = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             in_ready, out_valid, in_ready_h, out_valid_h;
  logic [WIDTH-1:0] out_c, out_d, out_c_h, out_d_h;
  logic [TAG_W-1:0] out_tag, out_tag_h;

  butterfly_pipe #(.WIDTH(WIDTH), .Q(Q), .TAG_W(TAG_W), .HALVE_INTT(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_a(in_a), .in_b(in_b), .in_w(in_w), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .out_d(out_d),
    .out_tag(out_tag));

  butterfly_pipe #(.WIDTH(WIDTH), .Q(Q), .TAG_W(TAG_W), .HALVE_INTT(1)) dut_h (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_h),
    .in_mode(in_mode), .in_a(in_a), .in_b(in_b), .in_w(in_w), .in_tag(in_tag),
    .out_valid(out_valid_h), .out_ready(out_ready), .out_c(out_c_h), .out_d(out_d_h),
    .out_tag(out_tag_h));

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] c, d, ch, dh;
    logic [7:0]  tag;
    int          cyc;
    bit          lat;
  } exp_t;

  typedef struct {
    logic [1:0] m;
    longint     a, b, w, c, d, ch, dh;
  } vec_t;

  exp_t   sb[$];
  exp_t   cur, head;
  vec_t   tv[14];
  int     n_vec = 0, n_err = 0, cyc = 0;
  bit     head_seen = 1'b0, lat_on = 1'b1, rnd_done = 1'b0;
  logic [7:0] tag_cnt = 8'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint nrm(input longint x);
    return (x < 0) ? x + QL : x;
  endfunction

  function automatic longint hv(input longint r);
    return (r % 2 == 0) ? r / 2 : (r + QL) / 2;
  endfunction

  function automatic exp_t model(input logic [1:0] m, input longint a0, input longint b0, input longint w0);
    exp_t e;
    longint a, b, w, t;
    a = nrm(a0); b = nrm(b0); w = nrm(w0);
    e = '{default: 0};
    case (m)
      2'b00: begin
        t = (w * b) % QL;
        e.c = 64'((a + t) % QL); e.d = 64'((a - t + QL) % QL);
        e.ch = e.c; e.dh = e.d;
      end
      2'b01: begin
        e.c = 64'((a + b) % QL); e.d = 64'((((a - b + QL) % QL) * w) % QL);
        e.ch = 64'(hv((a + b) % QL)); e.dh = 64'(hv((((a - b + QL) % QL) * w) % QL));
      end
      2'b10: begin
        e.c = 64'((a * b) % QL); e.d = 64'd0; e.ch = e.c; e.dh = e.d;
      end
      default: begin
        e.c = 64'(a); e.d = 64'(b); e.ch = e.c; e.dh = e.d;
      end
    endcase
    return e;
  endfunction

  function automatic longint rnd_op();
    return longint'($urandom_range(0, 2 * Q - 2)) - (QL - 1);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output checker and input-side scoreboard push, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious out_valid", 64'(out_valid), 64'd0);
        end else begin
          head = sb[0];
          check("out_c", 64'(out_c), head.c);
          check("out_d", 64'(out_d), head.d);
          check("out_tag", 64'(out_tag), 64'(head.tag));
          check("halved out_valid", 64'(out_valid_h), 64'd1);
          check("halved out_c", 64'(out_c_h), head.ch);
          check("halved out_d", 64'(out_d_h), head.dh);
          check("halved out_tag", 64'(out_tag_h), 64'(head.tag));
          if (!head_seen && head.lat) check("latency", 64'(cyc - head.cyc), 64'd4);
          head_seen = 1'b1;
          if (out_ready) begin
            void'(sb.pop_front());
            head_seen = 1'b0;
          end
        end
      end
      if (in_valid && in_ready) begin
        cur.cyc = cyc;
        sb.push_back(cur);
      end
    end
  end

  task automatic drive(input logic [1:0] m, input longint a, input longint b, input longint w, input exp_t e);
    int g;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_mode  = m;
    in_a     = a[WIDTH-1:0];
    in_b     = b[WIDTH-1:0];
    in_w     = w[WIDTH-1:0];
    in_tag   = tag_cnt;
    e.tag    = tag_cnt;
    e.lat    = lat_on;
    cur      = e;
    tag_cnt  = tag_cnt + 8'd1;
    g = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      g++;
      if (g > 100) begin
        check("in_ready timeout", 64'(in_ready), 64'd1);
        break;
      end
    end
  endtask

  task automatic drive_vec(input vec_t v);
    exp_t e;
    e = '{default: 0};
    e.c = 64'(v.c); e.d = 64'(v.d); e.ch = 64'(v.ch); e.dh = 64'(v.dh);
    drive(v.m, v.a, v.b, v.w, e);
  endtask

  task automatic drive_rnd(input logic [1:0] m);
    longint a, b, w;
    a = rnd_op(); b = rnd_op(); w = rnd_op();
    drive(m, a, b, w, model(m, a, b, w));
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 60) begin
      @(negedge clk);
      g++;
    end
    #1;
    check("scoreboard drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_reset_state();
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_c", 64'(out_c), 64'd0);
    check("reset out_d", 64'(out_d), 64'd0);
    check("reset out_tag", 64'(out_tag), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset halved out_valid", 64'(out_valid_h), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{2'b00, 0, 0, 25847, 0, 0, 0, 0};
    tv[1]  = '{2'b00, -2, 0, 25847, 8380415, 8380415, 8380415, 8380415};
    tv[2]  = '{2'b00, 0, -1, 25847, 8354570, 25847, 8354570, 25847};
    tv[3]  = '{2'b00, 2, 0, 25847, 2, 2, 2, 2};
    tv[4]  = '{2'b01, 3, 1, 5, 4, 10, 2, 5};
    tv[5]  = '{2'b01, 1, 0, 1, 1, 1, 4190209, 4190209};
    tv[6]  = '{2'b10, 3, 4, 25847, 12, 0, 12, 0};
    tv[7]  = '{2'b11, -1, 7, 25847, 8380416, 7, 8380416, 7};
    tv[8]  = '{2'b00, 8380416, 1, 1, 0, 8380415, 0, 8380415};
    tv[9]  = '{2'b01, 0, 1, 1, 1, 8380416, 4190209, 4190208};
    tv[10] = '{2'b10, -1, -1, 25847, 1, 0, 1, 0};
    tv[11] = '{2'b11, -8380416, 8380416, 0, 1, 8380416, 1, 8380416};
    tv[12] = '{2'b00, 5, -8380416, -1, 4, 6, 4, 6};
    tv[13] = '{2'b10, 8380416, 2, 0, 8380415, 0, 8380415, 0};

    repeat (2) @(posedge clk);
    #2;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while three samples are in flight; none may emerge.
    for (int i = 0; i < 3; i++) drive_rnd(2'b00);
    @(posedge clk); #3;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_state();
    sb.delete();
    head_seen = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state();
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Table vectors back to back, starting with the CT zero case after reset.
    for (int i = 0; i < 14; i++) drive_vec(tv[i]);
    idle();
    drain();

    // Backpressure: five stalled cycles once the first result appears.
    lat_on = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) drive_rnd(2'($urandom_range(0, 3)));
        idle();
      end
      begin
        int g;
        g = 0;
        do begin @(negedge clk); g++; end while (!out_valid && g < 20);
        check("first out_valid before stall", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("in_ready while stalled", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Random regression with random modes, gaps and out_ready.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 3000; i++) begin
          if ($urandom_range(0, 7) == 0) idle();
          drive_rnd(2'($urandom_range(0, 3)));
        end
        idle();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
